// File: rtl/serial_adder_if.sv
// ---------------------------------------------------------------------------
// serial_adder_if
// Request/result bundle between a requester and the bit-serial adder.
//
// Handshake: the requester raises start with a/b/cin valid; the adder takes
// the request on any rising clock edge where busy==0 (IDLE or DONE) and
// ignores it while busy==1. There is no back-pressure beyond busy and no
// queuing. done is a one-cycle pulse marking the cycle in which sum/cout
// first show the new result; they then hold until the next pulse.
//
// Signals:
//   start     requester -> adder  request pulse
//   a, b      requester -> adder  WIDTH-bit operands
//   cin       requester -> adder  carry-in
//   busy      adder -> requester  addition in progress
//   done      adder -> requester  result-updated pulse
//   sum       adder -> requester  WIDTH-bit registered result
//   cout      adder -> requester  registered carry-out
//   fsm_state adder -> requester  controller state, for debug/checkers
// ---------------------------------------------------------------------------
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [1:0]       fsm_state;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, fsm_state
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, fsm_state
    );
endinterface

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Bit-serial adder controller: one full-add cell (two half-adder stages and
// a carry OR) is reused for every bit position, LSB first, one bit per clock.
// An accepted start captures a/b/cin; WIDTH clocks later sum/cout update and
// done pulses for one cycle.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (clears all state, aborts any run)
//   bus   serial_adder_if.slave: start/a/b/cin in, busy/done/sum/cout and
//         fsm_state out
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    // One extra bit so the counter cannot wrap inside a single operation.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;

    logic             p;
    logic             g1;
    logic             s;
    logic             g2;
    logic             carry_next;
    logic             last_bit;
    logic             accept;

    // Shared full-add cell built from two half adders.
    always_comb begin
        p          = a_sh[0] ^ b_sh[0];
        g1         = a_sh[0] & b_sh[0];
        s          = p ^ carry;
        g2         = p & carry;
        carry_next = g1 | g2;
        last_bit   = (cnt == CW'(WIDTH - 1));
        // DONE accepts a new request exactly like IDLE (back-to-back use).
        accept     = bus.start && ((state == IDLE) || (state == DONE));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand/result shift registers, carry, bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            res_sh <= '0;
            carry  <= bus.cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            res_sh <= {s, res_sh[WIDTH-1:1]};
            carry  <= carry_next;
            cnt    <= cnt + CW'(1);
            // The final bit goes straight into sum alongside the shifted
            // partial result, so sum is complete on the edge entering DONE.
            if (last_bit) begin
                sum_q  <= {s, res_sh[WIDTH-1:1]};
                cout_q <= carry_next;
            end
        end
    end

    // Status outputs decode the state register directly, so they are glitch
    // free and busy/done are mutually exclusive by construction.
    always_comb begin
        bus.busy      = (state == RUN);
        bus.done      = (state == DONE);
        bus.sum       = sum_q;
        bus.cout      = cout_q;
        bus.fsm_state = state;
    end
endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder: an 8-bit instance for the table,
// corner sequences and random regression, and a 2-bit instance for an
// exhaustive sweep. Expected results are plain a+b+cin arithmetic.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_serial_adder;
    localparam int W  = 8;
    localparam int W2 = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W))  u8 ();
    serial_adder_if #(.WIDTH(W2)) u2 ();

    serial_adder #(.WIDTH(W))  dut8 (.clk(clk), .rst(rst), .bus(u8));
    serial_adder #(.WIDTH(W2)) dut2 (.clk(clk), .rst(rst), .bus(u2));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [W:0] exp_q[$];

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Issue one operation from an idle DUT and observe it to completion.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          output logic [W-1:0] s, output logic co, output int lat,
                          output int busy_n, output int overlap, output logic done_next);
        s = '0; co = 1'b0; lat = -1; busy_n = 0; overlap = 0; done_next = 1'b0;
        @(negedge clk);
        u8.start = 1'b1; u8.a = a; u8.b = b; u8.cin = cin;
        @(negedge clk);
        u8.start = 1'b0;
        for (int n = 1; n <= W + 4; n++) begin
            if (u8.busy) busy_n++;
            if (u8.busy && u8.done) overlap++;
            if (u8.done) begin
                lat = n - 1;
                s = u8.sum;
                co = u8.cout;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        done_next = u8.done;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [W-1:0] s;
        logic         co;
        logic         dn;
        int           lat, busy_n, overlap;
        int           done_n, first_done, last_done, bad_iv, unstable;
        logic [W-1:0] got_sum;
        logic         got_cout;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   expv;
        int           gap;
        bit           got;
        int           at_n;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

        u8.start = 1'b0; u8.a = '0; u8.b = '0; u8.cin = 1'b0;
        u2.start = 1'b0; u2.a = '0; u2.b = '0; u2.cin = 1'b0;

        // ---- reset ----
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", u8.busy, 0);
        check("reset_done", u8.done, 0);
        check("reset_sum",  u8.sum, 0);
        check("reset_cout", u8.cout, 0);

        // ---- table-driven vectors ----
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, s, co, lat, busy_n, overlap, dn);
            check($sformatf("tbl%0d_sum", i), s, tbl[i].sum);
            check($sformatf("tbl%0d_cout", i), co, tbl[i].cout);
            check($sformatf("tbl%0d_latency", i), lat, W);
            check($sformatf("tbl%0d_busy_cycles", i), busy_n, W);
            check($sformatf("tbl%0d_busy_done_overlap", i), overlap, 0);
            check($sformatf("tbl%0d_done_single", i), dn, 0);
        end

        // ---- start during RUN is ignored, operand changes have no effect ----
        @(negedge clk);
        u8.start = 1'b1; u8.a = 8'h10; u8.b = 8'h20; u8.cin = 1'b0;
        done_n = 0; got_sum = '0; got_cout = 1'b0;
        for (int n = 1; n <= 2 * W + 8; n++) begin
            @(negedge clk);
            if (u8.done) begin
                done_n++;
                if (done_n == 1) begin
                    got_sum = u8.sum;
                    got_cout = u8.cout;
                end
            end
            if (n == 4) begin
                u8.start = 1'b1; u8.a = 8'hAA; u8.b = 8'h55;
            end else begin
                u8.start = 1'b0; u8.a = 8'($urandom); u8.b = 8'($urandom);
                u8.cin = 1'($urandom_range(0, 1));
            end
        end
        u8.cin = 1'b0;
        check("ignore_done_count", done_n, 1);
        check("ignore_sum", got_sum, 8'h30);
        check("ignore_cout", got_cout, 0);
        check("ignore_sum_held", u8.sum, 8'h30);

        // ---- back-to-back with start held high ----
        @(negedge clk);
        u8.start = 1'b1; u8.a = 8'h01; u8.b = 8'h01; u8.cin = 1'b1;
        done_n = 0; first_done = -1; last_done = -1; bad_iv = 0; unstable = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (u8.done) begin
                done_n++;
                check("b2b_sum", u8.sum, 8'h03);
                check("b2b_cout", u8.cout, 0);
                if (first_done < 0) first_done = n;
                else if (n - last_done != W + 1) bad_iv++;
                last_done = n;
            end
            if (first_done >= 0 && (u8.sum !== 8'h03 || u8.cout !== 1'b0)) unstable++;
        end
        u8.start = 1'b0;
        check("b2b_first_done", first_done, W + 1);
        check("b2b_done_count", done_n, 4);
        check("b2b_interval", bad_iv, 0);
        check("b2b_sum_stable", unstable, 0);
        repeat (2 * W + 4) @(negedge clk);

        // ---- reset in the middle of a run ----
        u8.start = 1'b1; u8.a = 8'h7F; u8.b = 8'h01; u8.cin = 1'b0;
        @(negedge clk);
        u8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", u8.busy, 0);
        check("midrst_done", u8.done, 0);
        check("midrst_sum",  u8.sum, 0);
        check("midrst_cout", u8.cout, 0);
        done_n = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (u8.done) done_n++;
        end
        check("midrst_no_done", done_n, 0);
        run_op(8'h02, 8'h03, 1'b0, s, co, lat, busy_n, overlap, dn);
        check("midrst_fresh_sum", s, 8'h05);
        check("midrst_fresh_cout", co, 0);

        // ---- random regression against a+b+cin ----
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
            u8.start = 1'b1; u8.a = ra; u8.b = rb; u8.cin = rc;
            exp_q.push_back((W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc));
            got = 1'b0; at_n = 0;
            for (int n = 1; n <= W + 3; n++) begin
                @(negedge clk);
                if (u8.done) begin
                    got = 1'b1;
                    at_n = n;
                    break;
                end
                // Noise while running: starts and operand changes must be ignored.
                u8.start = 1'($urandom_range(0, 1));
                u8.a = 8'($urandom); u8.b = 8'($urandom);
                u8.cin = 1'($urandom_range(0, 1));
            end
            if (!got) begin
                n_vec++; n_err++;
                $display("FAIL rand_timeout: no done within %0d cycles, vector %0d", W + 3, i);
                exp_q.delete();
                break;
            end
            expv = exp_q.pop_front();
            check("rand_sum", {u8.cout, u8.sum}, expv);
            check("rand_latency", at_n, W + 1);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                u8.start = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        u8.start = 1'b0;
        repeat (2 * W + 4) @(negedge clk);

        // ---- WIDTH=2 exhaustive sweep ----
        for (int av = 0; av < 4; av++) begin
            for (int bv = 0; bv < 4; bv++) begin
                for (int c = 0; c < 2; c++) begin
                    u2.start = 1'b1; u2.a = 2'(av); u2.b = 2'(bv); u2.cin = 1'(c);
                    got = 1'b0;
                    for (int n = 1; n <= 8; n++) begin
                        @(negedge clk);
                        u2.start = 1'b0;
                        if (u2.done) begin
                            got = 1'b1;
                            break;
                        end
                    end
                    if (!got) begin
                        n_vec++; n_err++;
                        $display("FAIL w2_timeout: a=%0d b=%0d cin=%0d", av, bv, c);
                    end else begin
                        check($sformatf("w2_sum a=%0d b=%0d c=%0d", av, bv, c),
                              {u2.cout, u2.sum}, av + bv + c);
                    end
                    @(negedge clk);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
